// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle MIPS control path: opcode/funct values,
// ALU control codes, mux-select codes and the bundled control word.
package multicycle_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_OFF = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRC_B_REG    = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c = {$bits(ctrl_t){1'b0}};
    c.alu_ctrl = ALU_OFF;
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR fields and zero flag in, enables/selects out.
interface multicycle_controller_if #(
  parameter int COUNT_W = 32
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               pc_en;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         pc_src;
  logic [2:0]         alu_ctrl;
  logic               instr_done;
  logic               illegal;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    input  opcode, funct, zero,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_src, alu_ctrl, instr_done,
           illegal, instr_count
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_src, alu_ctrl, instr_done,
           illegal, instr_count
  );
endinterface

// File: rtl/multicycle_controller_alu_ctrl_decoder.sv
// R-type funct field to ALU control code; funct_ok flags a recognised funct.
module multicycle_controller_alu_ctrl_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_ok
);

  // funct lookup; unknown codes leave the ALU off
  always_comb begin
    alu_ctrl = ALU_OFF;
    funct_ok = 1'b0;
    case (funct)
      FN_ADD:  begin alu_ctrl = ALU_ADD; funct_ok = 1'b1; end
      FN_SUB:  begin alu_ctrl = ALU_SUB; funct_ok = 1'b1; end
      FN_AND:  begin alu_ctrl = ALU_AND; funct_ok = 1'b1; end
      FN_OR:   begin alu_ctrl = ALU_OR;  funct_ok = 1'b1; end
      FN_SLT:  begin alu_ctrl = ALU_SLT; funct_ok = 1'b1; end
      default: begin alu_ctrl = ALU_OFF; funct_ok = 1'b0; end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS core: steps each instruction through
// fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_controller_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_J_EX     = 4'd11
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [COUNT_W-1:0] count_r;
  ctrl_t              ctrl_s;
  logic [2:0]         dec_alu_s;
  logic               dec_ok_s;

  multicycle_controller_alu_ctrl_decoder u_alu_dec (
    .funct    (bus.funct),
    .alu_ctrl (dec_alu_s),
    .funct_ok (dec_ok_s)
  );

  // state register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
      count_r <= {COUNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (ctrl_s.instr_done) begin
        count_r <= count_r + COUNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // next state and control word; reset forces the idle word so no write strobe can leak
  always_comb begin
    ctrl_s       = ctrl_idle();
    state_next_s = S_FETCH;
    if (rst) begin
      ctrl_s       = ctrl_idle();
      state_next_s = S_FETCH;
    end else begin
      case (state_r)
        S_FETCH: begin
          ctrl_s.mem_read  = 1'b1;
          ctrl_s.ir_write  = 1'b1;
          ctrl_s.alu_src_b = SRC_B_FOUR;
          ctrl_s.alu_ctrl  = ALU_ADD;
          ctrl_s.pc_write  = 1'b1;
          ctrl_s.pc_src    = PC_SRC_ALU;
          state_next_s     = S_DECODE;
        end
        S_DECODE: begin
          ctrl_s.alu_src_b = SRC_B_IMM_SH;
          ctrl_s.alu_ctrl  = ALU_ADD;
          case (bus.opcode)
            OP_LW, OP_SW: state_next_s = S_MEMADR;
            OP_RTYPE:     state_next_s = S_RTYPE_EX;
            OP_BEQ:       state_next_s = S_BEQ_EX;
            OP_ADDI:      state_next_s = S_ADDI_EX;
            OP_J:         state_next_s = S_J_EX;
            default: begin
              ctrl_s.illegal = 1'b1;
              state_next_s   = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          ctrl_s.alu_src_a = 1'b1;
          ctrl_s.alu_src_b = SRC_B_IMM;
          ctrl_s.alu_ctrl  = ALU_ADD;
          if (bus.opcode == OP_LW) begin
            state_next_s = S_MEMRD;
          end else begin
            state_next_s = S_MEMWR;
          end
        end
        S_MEMRD: begin
          ctrl_s.mem_read = 1'b1;
          ctrl_s.iord     = 1'b1;
          state_next_s    = S_MEMWB;
        end
        S_MEMWB: begin
          ctrl_s.reg_write  = 1'b1;
          ctrl_s.mem_to_reg = 1'b1;
          ctrl_s.instr_done = 1'b1;
        end
        S_MEMWR: begin
          ctrl_s.mem_write  = 1'b1;
          ctrl_s.iord       = 1'b1;
          ctrl_s.instr_done = 1'b1;
        end
        S_RTYPE_EX: begin
          ctrl_s.alu_src_a = 1'b1;
          ctrl_s.alu_src_b = SRC_B_REG;
          ctrl_s.alu_ctrl  = dec_alu_s;
          if (dec_ok_s) begin
            state_next_s = S_RTYPE_WB;
          end else begin
            ctrl_s.illegal = 1'b1;
            state_next_s   = S_FETCH;
          end
        end
        S_RTYPE_WB: begin
          ctrl_s.reg_write  = 1'b1;
          ctrl_s.reg_dst    = 1'b1;
          ctrl_s.instr_done = 1'b1;
        end
        S_BEQ_EX: begin
          ctrl_s.alu_src_a     = 1'b1;
          ctrl_s.alu_src_b     = SRC_B_REG;
          ctrl_s.alu_ctrl      = ALU_SUB;
          ctrl_s.pc_write_cond = 1'b1;
          ctrl_s.pc_src        = PC_SRC_ALUOUT;
          ctrl_s.instr_done    = 1'b1;
        end
        S_ADDI_EX: begin
          ctrl_s.alu_src_a = 1'b1;
          ctrl_s.alu_src_b = SRC_B_IMM;
          ctrl_s.alu_ctrl  = ALU_ADD;
          state_next_s     = S_ADDI_WB;
        end
        S_ADDI_WB: begin
          ctrl_s.reg_write  = 1'b1;
          ctrl_s.instr_done = 1'b1;
        end
        S_J_EX: begin
          ctrl_s.pc_write   = 1'b1;
          ctrl_s.pc_src     = PC_SRC_JUMP;
          ctrl_s.instr_done = 1'b1;
        end
        default: begin
          ctrl_s       = ctrl_idle();
          state_next_s = S_FETCH;
        end
      endcase
    end
  end

  assign bus.pc_en       = ctrl_s.pc_write | (ctrl_s.pc_write_cond & bus.zero);
  assign bus.iord        = ctrl_s.iord;
  assign bus.mem_read    = ctrl_s.mem_read;
  assign bus.mem_write   = ctrl_s.mem_write;
  assign bus.ir_write    = ctrl_s.ir_write;
  assign bus.reg_dst     = ctrl_s.reg_dst;
  assign bus.mem_to_reg  = ctrl_s.mem_to_reg;
  assign bus.reg_write   = ctrl_s.reg_write;
  assign bus.alu_src_a   = ctrl_s.alu_src_a;
  assign bus.alu_src_b   = ctrl_s.alu_src_b;
  assign bus.pc_src      = ctrl_s.pc_src;
  assign bus.alu_ctrl    = ctrl_s.alu_ctrl;
  assign bus.instr_done  = ctrl_s.instr_done;
  assign bus.illegal     = ctrl_s.illegal;
  assign bus.instr_count = count_r;

endmodule
